// File: rtl/symbol_reorder.sv
// symbol_reorder: ping-pong symbol reorderer for the Ethernet receive path.
//
// Incoming symbols are grouped into words of SYMS symbols. Each word is sent
// out with its symbol order reversed, so the last symbol received comes out
// first. There are two word buffers. One buffer drains while the other fills,
// so a stream of one symbol per cycle passes through without stalls.
//
// Parameters:
//   SYM_W       symbol width in bits (>= 1)
//   SYMS        symbols per word (>= 2)
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   axiiv       input symbol valid
//   axiid       input symbol
//   axiov       output symbol valid (registered)
//   axiod       output symbol, zero when axiov is low (registered)
//   frag        one-cycle pulse: a partial word was discarded
//   frag_count  saturating fragment count, present only when the macro
//               SYMBOL_REORDER_FRAG_CNT_EN is defined
//
// There is no explicit state register. The operating mode (idle, fill,
// drain) follows from the full flags and the fill index.
module symbol_reorder #(
  parameter int unsigned SYM_W = 2,
  parameter int unsigned SYMS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             axiiv,
  input  logic [SYM_W-1:0] axiid,
  output logic             axiov,
  output logic [SYM_W-1:0] axiod,
  output logic             frag
`ifdef SYMBOL_REORDER_FRAG_CNT_EN
  ,
  output logic [7:0]       frag_count
`endif
);

  localparam int unsigned IdxW = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SYMS - 1);

  typedef logic [SYM_W-1:0] sym_t;

  sym_t            word_q [2][SYMS];
  sym_t            word_d [2][SYMS];
  logic [1:0]      full_q, full_d;
  logic            fill_sel_q, fill_sel_d;
  logic [IdxW-1:0] fill_idx_q, fill_idx_d;
  logic            drain_sel_q, drain_sel_d;
  logic [IdxW-1:0] drain_idx_q, drain_idx_d;
  logic            axiov_q, axiov_d;
  sym_t            axiod_q, axiod_d;
  logic            frag_q, frag_d;

  always_comb begin
    word_d      = word_q;
    full_d      = full_q;
    fill_sel_d  = fill_sel_q;
    fill_idx_d  = fill_idx_q;
    drain_sel_d = drain_sel_q;
    drain_idx_d = drain_idx_q;
    frag_d      = 1'b0;

    // Advance the drain. drain_idx_q is the slot currently shown on the output.
    if (full_q[drain_sel_q]) begin
      if (drain_idx_q == '0) begin
        full_d[drain_sel_q] = 1'b0;
      end else begin
        drain_idx_d = drain_idx_q - IdxW'(1);
      end
    end

    if (axiiv) begin
      word_d[fill_sel_q][fill_idx_q] = axiid;
      if (fill_idx_q == LastIdx) begin
        // Completion comes after the drain clear, so it wins on the same edge.
        full_d[fill_sel_q] = 1'b1;
        fill_idx_d         = '0;
        fill_sel_d         = ~fill_sel_q;
        drain_sel_d        = fill_sel_q;
        drain_idx_d        = LastIdx;
      end else begin
        fill_idx_d = fill_idx_q + IdxW'(1);
      end
    end else if (fill_idx_q != '0) begin
      // Partial word: discard it. An ongoing drain of the other buffer is untouched.
      for (int unsigned k = 0; k < SYMS; k++) begin
        word_d[fill_sel_q][IdxW'(k)] = '0;
      end
      fill_idx_d = '0;
      frag_d     = 1'b1;
    end

    // Outputs are registered from next state, so the first symbol of a word is
    // visible the cycle right after its last slot is captured.
    axiov_d = full_d[drain_sel_d];
    axiod_d = axiov_d ? word_d[drain_sel_d][drain_idx_d] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '{default: '0};
      full_q      <= '0;
      fill_sel_q  <= 1'b0;
      fill_idx_q  <= '0;
      drain_sel_q <= 1'b0;
      drain_idx_q <= '0;
      axiov_q     <= 1'b0;
      axiod_q     <= '0;
      frag_q      <= 1'b0;
    end else begin
      word_q      <= word_d;
      full_q      <= full_d;
      fill_sel_q  <= fill_sel_d;
      fill_idx_q  <= fill_idx_d;
      drain_sel_q <= drain_sel_d;
      drain_idx_q <= drain_idx_d;
      axiov_q     <= axiov_d;
      axiod_q     <= axiod_d;
      frag_q      <= frag_d;
    end
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;
  assign frag  = frag_q;

`ifdef SYMBOL_REORDER_FRAG_CNT_EN
  logic [7:0] frag_cnt_q;

  // Counts along with the frag register, so the count and the pulse appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frag_cnt_q <= '0;
    end else if (frag_d && (frag_cnt_q != 8'hFF)) begin
      frag_cnt_q <= frag_cnt_q + 8'd1;
    end
  end

  assign frag_count = frag_cnt_q;
`endif

endmodule

// File: tb/tb_symbol_reorder.sv
// Bench for symbol_reorder. A queue-based reference model turns the captured
// input stream into the expected output stream. Each completed word is reversed
// and appended to an output queue, and one symbol leaves that queue per cycle.
module tb_symbol_reorder;

  localparam int unsigned SYM_W = 2;
  localparam int unsigned SYMS  = 4;

  logic             clk;
  logic             rst_n;
  logic             axiiv;
  logic [SYM_W-1:0] axiid;
  logic             axiov;
  logic [SYM_W-1:0] axiod;
  logic             frag;
`ifdef SYMBOL_REORDER_FRAG_CNT_EN
  logic [7:0]       frag_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [SYM_W-1:0] part_q[$];
  logic [SYM_W-1:0] exp_q[$];
  int               frag_cnt_m = 0;

  symbol_reorder #(
    .SYM_W(SYM_W),
    .SYMS (SYMS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .axiiv(axiiv),
    .axiid(axiid),
    .axiov(axiov),
    .axiod(axiod),
    .frag (frag)
`ifdef SYMBOL_REORDER_FRAG_CNT_EN
    ,
    .frag_count(frag_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, update the model with what the edge captured,
  // then compare the outputs 1 time unit after the edge.
  task automatic drive_cycle(input logic v, input logic [SYM_W-1:0] d);
    logic             exp_v;
    logic [SYM_W-1:0] exp_d;
    logic             exp_frag;
    axiiv = v;
    axiid = d;
    @(posedge clk);
    #1;
    exp_frag = 1'b0;
    if (v) begin
      part_q.push_back(d);
      if (part_q.size() == SYMS) begin
        for (int k = SYMS - 1; k >= 0; k--) exp_q.push_back(part_q[k]);
        part_q.delete();
      end
    end else if (part_q.size() != 0) begin
      part_q.delete();
      exp_frag = 1'b1;
      if (frag_cnt_m < 255) frag_cnt_m++;
    end
    if (exp_q.size() != 0) begin
      exp_v = 1'b1;
      exp_d = exp_q.pop_front();
    end else begin
      exp_v = 1'b0;
      exp_d = '0;
    end
    check("axiov", 32'(axiov), 32'(exp_v));
    check("axiod", 32'(axiod), 32'(exp_d));
    check("frag", 32'(frag), 32'(exp_frag));
`ifdef SYMBOL_REORDER_FRAG_CNT_EN
    check("frag_count", 32'(frag_count), 32'(frag_cnt_m));
`endif
  endtask

  task automatic send_word(input logic [7:0] w);
    logic [7:0] t;
    t = w;
    for (int k = 0; k < SYMS; k++) drive_cycle(1'b1, t[2*k +: 2]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0);
  endtask

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    frag_cnt_m = 0;
  endtask

  initial begin
    logic [7:0] bytes [3];
    rst_n = 1'b0;
    axiiv = 1'b0;
    axiid = '0;
    #12;
    check("reset_axiov", 32'(axiov), 32'd0);
    check("reset_axiod", 32'(axiod), 32'd0);
    check("reset_frag", 32'(frag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word 0,1,2,3 -> 3,2,1,0.
    for (int k = 0; k < SYMS; k++) drive_cycle(1'b1, SYM_W'(k));
    idle(6);

    // Back-to-back words, gapless output.
    bytes[0] = 8'hE4;
    bytes[1] = 8'h1B;
    bytes[2] = 8'h93;
    for (int b = 0; b < 3; b++) send_word(bytes[b]);
    idle(6);

    // Fragment, then a full word 1,2,3,0.
    drive_cycle(1'b1, 2'd2);
    drive_cycle(1'b1, 2'd1);
    idle(2);
    drive_cycle(1'b1, 2'd1);
    drive_cycle(1'b1, 2'd2);
    drive_cycle(1'b1, 2'd3);
    drive_cycle(1'b1, 2'd0);
    idle(6);

    // Gap of three idle cycles at a word boundary.
    send_word(8'h6C);
    idle(3);
    send_word(8'hB1);
    idle(6);

    // Fragment arriving while the previous word drains.
    send_word(8'h27);
    drive_cycle(1'b1, 2'd3);
    drive_cycle(1'b1, 2'd1);
    idle(6);

    // Randomized stream with occasional idle cycles.
    for (int i = 0; i < 600; i++) begin
      drive_cycle(($urandom_range(0, 7) != 0), SYM_W'($urandom_range(0, (1 << SYM_W) - 1)));
    end
    idle(8);

    // Reset in the middle of a drain, after two output symbols.
    send_word(8'hD8);
    drive_cycle(1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("middrain_axiov", 32'(axiov), 32'd0);
    check("middrain_axiod", 32'(axiod), 32'd0);
    check("middrain_frag", 32'(frag), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(8'h4E);
    idle(6);

    // 300 fragments: each is one valid symbol followed by an idle cycle.
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'b1, SYM_W'($urandom_range(0, (1 << SYM_W) - 1)));
      drive_cycle(1'b0, '0);
    end
`ifdef SYMBOL_REORDER_FRAG_CNT_EN
    check("frag_count_saturated", 32'(frag_count), 32'd255);
`endif
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
